// File: rtl/demux_scan_pkg.sv
// Shared definitions for the demux_scan_led LED driver: mode encoding,
// sweep direction and a width helper that never returns zero.
package demux_scan_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Width needed to index n items, but at least one bit so that a
    // single-channel instance still has a legal select port.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_scan_led_step_tick.sv
// step_tick: free-running divider that emits a one-cycle tick every
// STEP_DIV clocks. A synchronous restart puts the count back to zero so
// the first tick after a restart lands exactly STEP_DIV cycles later.
module step_tick
    import demux_scan_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int               CNT_W    = clog2_min1(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             atLast;

    assign atLast = (cnt_q == CNT_LAST);

    // The restart cycle itself never produces a tick.
    assign tick_o = atLast && !restart_i;

    // Count 0..STEP_DIV-1, wrapping on the terminal count or on restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || atLast) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_scan_led.sv
// demux_scan_led: registered 1-to-N demultiplexer for LED banks with four
// run-time modes (direct, per-channel latch, wrapping scan, ping-pong
// bounce). Every output is a flop, so inputs show up one clock later.
module demux_scan_led
    import demux_scan_pkg::*;
#(
    parameter int N_OUT    = 8,
    parameter int SEL_W    = clog2_min1(N_OUT),
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             data,
    input  logic             wr_en,
    input  logic             clr,
    output logic [N_OUT-1:0] out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap
);

    // N_OUT held one bit wider than sel so N_OUT = 2**SEL_W still fits.
    localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W + 1)'(N_OUT);
    localparam logic [SEL_W-1:0] PTR_LAST  = SEL_W'(N_OUT - 1);

    mode_t            modeNow;
    mode_t            prevMode_q;
    logic             isSweep;
    logic             modeEntry;
    logic             selInRange;
    logic             stepTick;
    logic             goUp;

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    dir_t             dir_q;
    dir_t             dir_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [N_OUT-1:0] out_q;
    logic [N_OUT-1:0] out_d;
    logic [SEL_W-1:0] curSel_q;
    logic [SEL_W-1:0] curSel_d;

    assign modeNow    = mode_t'(mode);
    assign isSweep    = (modeNow == MODE_SCAN) || (modeNow == MODE_BOUNCE);
    assign modeEntry  = isSweep && (modeNow != prevMode_q);
    assign selInRange = ({1'b0, sel} < N_OUT_EXT);

    step_tick #(
        .STEP_DIV (STEP_DIV)
    ) uStepTick (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (modeEntry),
        .tick_o    (stepTick)
    );

    // Pointer, direction and wrap pulse: load on sweep entry, then advance
    // on each divider tick (wrapping in SCAN, reversing at ends in BOUNCE).
    always_comb begin
        ptr_d  = ptr_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        goUp   = 1'b0;
        if (modeEntry) begin
            ptr_d = selInRange ? sel : '0;
            dir_d = DIR_UP;
        end else if (isSweep && stepTick && (N_OUT > 1)) begin
            if (modeNow == MODE_SCAN) begin
                if (ptr_q == PTR_LAST) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else begin
                goUp = ((dir_q == DIR_UP) && (ptr_q != PTR_LAST)) ||
                       ((dir_q == DIR_DOWN) && (ptr_q == '0));
                ptr_d = goUp ? (ptr_q + 1'b1) : (ptr_q - 1'b1);
                if (ptr_d == PTR_LAST) begin
                    dir_d  = DIR_DOWN;
                    wrap_d = 1'b1;
                end else if (ptr_d == '0) begin
                    dir_d  = DIR_UP;
                    wrap_d = 1'b1;
                end else begin
                    dir_d = goUp ? DIR_UP : DIR_DOWN;
                end
            end
        end
    end

    // Next LED image and reported channel for the active mode.
    always_comb begin
        out_d    = out_q;
        curSel_d = sel;
        case (modeNow)
            MODE_DIRECT: begin
                for (int i = 0; i < N_OUT; i++) begin
                    out_d[i] = data && (sel == SEL_W'(i));
                end
            end
            MODE_LATCH: begin
                if (clr) begin
                    out_d = '0;
                end else if (wr_en) begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (sel == SEL_W'(i)) begin
                            out_d[i] = data;
                        end
                    end
                end
            end
            default: begin
                curSel_d = ptr_d;
                for (int i = 0; i < N_OUT; i++) begin
                    out_d[i] = data && (ptr_d == SEL_W'(i));
                end
            end
        endcase
    end

    // All architectural state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            dir_q      <= DIR_UP;
            wrap_q     <= 1'b0;
            out_q      <= '0;
            curSel_q   <= '0;
            prevMode_q <= MODE_DIRECT;
        end else begin
            ptr_q      <= ptr_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
            out_q      <= out_d;
            curSel_q   <= curSel_d;
            prevMode_q <= modeNow;
        end
    end

    assign out     = out_q;
    assign cur_sel = curSel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_demux_scan_led.sv
// Scoreboard bench for demux_scan_led: three instances (8 ch / div 4,
// 4 ch / div 1, 6 ch / div 4). Stimulus queues hand-computed expectations
// tagged with the clock count; a monitor pops and compares them.
module tb_demux_scan_led;

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_LATCH  = 2'b01;
    localparam logic [1:0] M_SCAN   = 2'b10;
    localparam logic [1:0] M_BOUNCE = 2'b11;

    typedef struct packed {
        int         tag;
        int         dut;
        logic [7:0] out;
        logic [7:0] sel;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t  sbQ[$];
    string nameQ[$];
    event  asyncSample;

    logic [1:0] mode0, mode1, mode2;
    logic [2:0] sel0, sel2;
    logic [1:0] sel1;
    logic       data0, data1, data2;
    logic       wr0, wr1, wr2;
    logic       clr0, clr1, clr2;
    logic [7:0] out0;
    logic [3:0] out1;
    logic [5:0] out2;
    logic [2:0] cur0, cur2;
    logic [1:0] cur1;
    logic       wrap0, wrap1, wrap2;

    int scanSel[13]   = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0, 0, 0, 1};
    int bounceSel[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};

    demux_scan_led #(.N_OUT(8), .STEP_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .mode(mode0), .sel(sel0), .data(data0),
        .wr_en(wr0), .clr(clr0), .out(out0), .cur_sel(cur0), .wrap(wrap0)
    );

    demux_scan_led #(.N_OUT(4), .STEP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .sel(sel1), .data(data1),
        .wr_en(wr1), .clr(clr1), .out(out1), .cur_sel(cur1), .wrap(wrap1)
    );

    demux_scan_led #(.N_OUT(6), .STEP_DIV(4)) dut2 (
        .clk(clk), .rst(rst), .mode(mode2), .sel(sel2), .data(data2),
        .wr_en(wr2), .clr(clr2), .out(out2), .cur_sel(cur2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input int d, input logic [1:0] m, input logic [7:0] s,
                                 input logic dt, input logic w, input logic c);
        case (d)
            0: begin mode0 = m; sel0 = s[2:0]; data0 = dt; wr0 = w; clr0 = c; end
            1: begin mode1 = m; sel1 = s[1:0]; data1 = dt; wr1 = w; clr1 = c; end
            default: begin mode2 = m; sel2 = s[2:0]; data2 = dt; wr2 = w; clr2 = c; end
        endcase
    endtask

    task automatic pushExpect(input int d, input int ofs, input string name,
                              input logic [7:0] eo, input logic [7:0] es, input logic ew);
        exp_t e;
        e.tag  = cyc + ofs;
        e.dut  = d;
        e.out  = eo;
        e.sel  = es;
        e.wrap = ew;
        sbQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic vec(input int d, input logic [1:0] m, input logic [7:0] s,
                       input logic dt, input logic w, input logic c, input string name,
                       input logic [7:0] eo, input logic [7:0] es, input logic ew);
        applyStimulus(d, m, s, dt, w, c);
        pushExpect(d, 1, name, eo, es, ew);
        @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic [7:0] aOut;
        logic [7:0] aSel;
        logic       aWrap;
        case (e.dut)
            0: begin aOut = out0; aSel = {5'b0, cur0}; aWrap = wrap0; end
            1: begin aOut = {4'b0, out1}; aSel = {6'b0, cur1}; aWrap = wrap1; end
            default: begin aOut = {2'b0, out2}; aSel = {5'b0, cur2}; aWrap = wrap2; end
        endcase
        checks++;
        if (aOut !== e.out || aSel !== e.sel || aWrap !== e.wrap) begin
            errors++;
            $display("[TB] FAIL %s (dut%0d, cycle %0d): got out=%h cur_sel=%0d wrap=%b, expected out=%h cur_sel=%0d wrap=%b",
                     name, e.dut, cyc, aOut, aSel, aWrap, e.out, e.sel, e.wrap);
        end
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    initial begin
        forever begin
            @(negedge clk or asyncSample);
            while (sbQ.size() > 0 && sbQ[0].tag <= cyc) begin
                checkOutput(sbQ.pop_front(), nameQ.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, M_DIRECT, 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, M_DIRECT, 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, M_DIRECT, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) pushExpect(d, 1, "reset", 8'h00, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Direct routing
        vec(0, M_DIRECT, 8'd5, 1'b1, 1'b0, 1'b0, "direct_s5_d1", 8'h20, 8'd5, 1'b0);
        vec(0, M_DIRECT, 8'd5, 1'b0, 1'b0, 1'b0, "direct_s5_d0", 8'h00, 8'd5, 1'b0);
        vec(0, M_DIRECT, 8'd7, 1'b1, 1'b0, 1'b0, "direct_s7_d1", 8'h80, 8'd7, 1'b0);

        // Latch: keeps direct image, then writes, hold, clr beats wr_en
        vec(0, M_LATCH, 8'd7, 1'b0, 1'b0, 1'b0, "latch_entry_hold", 8'h80, 8'd7, 1'b0);
        vec(0, M_LATCH, 8'd7, 1'b0, 1'b0, 1'b1, "latch_clr", 8'h00, 8'd7, 1'b0);
        vec(0, M_LATCH, 8'd2, 1'b1, 1'b1, 1'b0, "latch_wr2", 8'h04, 8'd2, 1'b0);
        vec(0, M_LATCH, 8'd6, 1'b1, 1'b1, 1'b0, "latch_wr6", 8'h44, 8'd6, 1'b0);
        vec(0, M_LATCH, 8'd3, 1'b1, 1'b0, 1'b0, "latch_nowr_hold", 8'h44, 8'd3, 1'b0);
        vec(0, M_LATCH, 8'd0, 1'b1, 1'b1, 1'b1, "latch_clr_over_wr", 8'h00, 8'd0, 1'b0);

        // Scan from 6 with divide-by-4: 6,7 then wrap to 0
        applyStimulus(0, M_SCAN, 8'd6, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            pushExpect(0, k + 1, "scan_sweep", 8'(1 << scanSel[k]), 8'(scanSel[k]), (k == 8));
        end
        repeat (13) @(negedge clk);
        vec(0, M_SCAN, 8'd6, 1'b0, 1'b0, 1'b0, "scan_data_toggle", 8'h00, 8'd1, 1'b0);

        // Bounce on 4 channels stepping every clock
        applyStimulus(1, M_BOUNCE, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            pushExpect(1, k + 1, "bounce_sweep", 8'(1 << bounceSel[k]), 8'(bounceSel[k]),
                       (k == 3) || (k == 6));
        end
        repeat (8) @(negedge clk);

        // Six channels: out-of-range select handling
        vec(2, M_DIRECT, 8'd2, 1'b1, 1'b0, 1'b0, "n6_direct_s2", 8'h04, 8'd2, 1'b0);
        vec(2, M_DIRECT, 8'd7, 1'b1, 1'b0, 1'b0, "n6_direct_s7", 8'h00, 8'd7, 1'b0);
        vec(2, M_LATCH, 8'd3, 1'b1, 1'b1, 1'b0, "n6_latch_wr3", 8'h08, 8'd3, 1'b0);
        vec(2, M_LATCH, 8'd7, 1'b0, 1'b1, 1'b0, "n6_latch_wr7", 8'h08, 8'd7, 1'b0);
        vec(2, M_LATCH, 8'd5, 1'b1, 1'b1, 1'b0, "n6_latch_wr5", 8'h28, 8'd5, 1'b0);
        applyStimulus(2, M_SCAN, 8'd7, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            pushExpect(2, k, "n6_scan_s7", (k == 5) ? 8'h02 : 8'h01, (k == 5) ? 8'd1 : 8'd0, 1'b0);
        end
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-scan at channel 3, then restart from sel
        vec(0, M_DIRECT, 8'd3, 1'b1, 1'b0, 1'b0, "pre_scan_direct", 8'h08, 8'd3, 1'b0);
        vec(0, M_SCAN, 8'd3, 1'b1, 1'b0, 1'b0, "scan_entry_s3", 8'h08, 8'd3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        pushExpect(0, 0, "async_rst", 8'h00, 8'd0, 1'b0);
        -> asyncSample;
        pushExpect(0, 1, "rst_held", 8'h00, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pushExpect(0, k, "scan_after_rst", (k == 5) ? 8'h10 : 8'h08, (k == 5) ? 8'd4 : 8'd3, 1'b0);
        end
        repeat (5) @(negedge clk);

        repeat (2) @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
